// File: rtl/mix_column_iter.sv
// mix_column_iter: iterative AES MixColumns stage, one column per clock.
// A state is captured in IDLE. CALC then writes result columns 0..3 into
// Data_Out, one per cycle. DONE presents the result until Out_Ready is high.
// Last_Round=1 copies each column through unchanged, with the same timing.
// Optional feature: define MIXCOL_INV_EN to add the Decrypt port. A captured
// Decrypt=1 then selects InvMixColumns.
module mix_column_iter (
    input  logic         clk,
    input  logic         reset,
    input  logic [0:127] Data_In,
    input  logic         In_Valid,
    output logic         In_Ready,
    input  logic         Last_Round,
`ifdef MIXCOL_INV_EN
    input  logic         Decrypt,
`endif
    output logic [0:127] Data_Out,
    output logic         Out_Valid,
    input  logic         Out_Ready
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] CALC = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]   fsm_q, fsm_d;
    logic [1:0]   col_q, col_d;
    logic         last_q, last_d;
    logic         cap_en;
    logic [0:127] state_q;
    logic [0:127] data_out_q, data_out_d;
    logic [31:0]  col_in;
    logic [31:0]  col_res;
`ifdef MIXCOL_INV_EN
    logic         dec_q, dec_d;
`endif

    // Multiply by x in GF(2^8), reducing modulo x^8+x^4+x^3+x+1 (0x11B).
    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    // Forward MixColumns on one column; row 0 byte sits in bits [31:24].
    function automatic logic [31:0] mix_fwd(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        logic [7:0] x0, x1, x2, x3;
        logic [7:0] r0, r1, r2, r3;
        a0 = col[31:24];
        a1 = col[23:16];
        a2 = col[15:8];
        a3 = col[7:0];
        x0 = xtime(a0);
        x1 = xtime(a1);
        x2 = xtime(a2);
        x3 = xtime(a3);
        // Rows {02,03,01,01} rotated right by row index; 03*a = xtime(a)^a.
        r0 = x0 ^ (x1 ^ a1) ^ a2 ^ a3;
        r1 = a0 ^ x1 ^ (x2 ^ a2) ^ a3;
        r2 = a0 ^ a1 ^ x2 ^ (x3 ^ a3);
        r3 = (x0 ^ a0) ^ a1 ^ a2 ^ x3;
        return {r0, r1, r2, r3};
    endfunction

`ifdef MIXCOL_INV_EN
    // Multiply a byte by 09, 0b, 0d and 0e, built from repeated xtime.
    function automatic logic [31:0] inv_mults(input logic [7:0] a);
        logic [7:0] m2, m4, m8;
        m2 = xtime(a);
        m4 = xtime(m2);
        m8 = xtime(m4);
        // Packed as {09*a, 0b*a, 0d*a, 0e*a}.
        return {m8 ^ a, m8 ^ m2 ^ a, m8 ^ m4 ^ a, m8 ^ m4 ^ m2};
    endfunction

    // Inverse MixColumns on one column, rows {0e,0b,0d,09} rotated.
    function automatic logic [31:0] mix_inv(input logic [31:0] col);
        logic [31:0] p0, p1, p2, p3;
        logic [7:0]  r0, r1, r2, r3;
        p0 = inv_mults(col[31:24]);
        p1 = inv_mults(col[23:16]);
        p2 = inv_mults(col[15:8]);
        p3 = inv_mults(col[7:0]);
        // Field layout of each p: [31:24]=09, [23:16]=0b, [15:8]=0d, [7:0]=0e.
        r0 = p0[7:0]   ^ p1[23:16] ^ p2[15:8]  ^ p3[31:24];
        r1 = p0[31:24] ^ p1[7:0]   ^ p2[23:16] ^ p3[15:8];
        r2 = p0[15:8]  ^ p1[31:24] ^ p2[7:0]   ^ p3[23:16];
        r3 = p0[23:16] ^ p1[15:8]  ^ p2[31:24] ^ p3[7:0];
        return {r0, r1, r2, r3};
    endfunction
`endif

    // Handshake flags decode directly from the registered state.
    assign In_Ready  = (fsm_q == IDLE);
    assign Out_Valid = (fsm_q == DONE);
    assign Data_Out  = data_out_q;

    // Select the captured column addressed by the column counter.
    always_comb begin
        col_in = 32'h0;
        case (col_q)
            2'd0:    col_in = state_q[0:31];
            2'd1:    col_in = state_q[32:63];
            2'd2:    col_in = state_q[64:95];
            default: col_in = state_q[96:127];
        endcase
    end

    // Column result: bypass on the last round, otherwise forward or inverse mix.
    always_comb begin
        col_res = mix_fwd(col_in);
`ifdef MIXCOL_INV_EN
        if (dec_q) begin
            col_res = mix_inv(col_in);
        end
`endif
        if (last_q) begin
            col_res = col_in;
        end
    end

    // Next-state, counter, flag capture and output column write-back.
    always_comb begin
        fsm_d      = fsm_q;
        col_d      = col_q;
        last_d     = last_q;
        cap_en     = 1'b0;
        data_out_d = data_out_q;
`ifdef MIXCOL_INV_EN
        dec_d      = dec_q;
`endif
        case (fsm_q)
            IDLE: begin
                if (In_Valid) begin
                    cap_en = 1'b1;
                    last_d = Last_Round;
`ifdef MIXCOL_INV_EN
                    dec_d  = Decrypt;
`endif
                    col_d  = 2'd0;
                    fsm_d  = CALC;
                end
            end
            CALC: begin
                case (col_q)
                    2'd0:    data_out_d[0:31]   = col_res;
                    2'd1:    data_out_d[32:63]  = col_res;
                    2'd2:    data_out_d[64:95]  = col_res;
                    default: data_out_d[96:127] = col_res;
                endcase
                col_d = col_q + 2'd1;
                if (col_q == 2'd3) begin
                    fsm_d = DONE;
                end
            end
            DONE: begin
                // Result stays frozen until the consumer takes it.
                if (Out_Ready) begin
                    fsm_d = IDLE;
                end
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // Control and result registers; reset drops any in-flight state.
    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q      <= IDLE;
            col_q      <= 2'd0;
            last_q     <= 1'b0;
            data_out_q <= 128'h0;
`ifdef MIXCOL_INV_EN
            dec_q      <= 1'b0;
`endif
        end else begin
            fsm_q      <= fsm_d;
            col_q      <= col_d;
            last_q     <= last_d;
            data_out_q <= data_out_d;
`ifdef MIXCOL_INV_EN
            dec_q      <= dec_d;
`endif
        end
    end

    // Captured input state; only read during CALC, so it needs no reset.
    always_ff @(posedge clk) begin
        if (cap_en) begin
            state_q <= Data_In;
        end
    end

endmodule

// File: tb/tb_mix_column_iter.sv
// tb_mix_column_iter: table-driven vectors with a queue scoreboard, plus
// hand sequences for backpressure, column progression and reset mid-CALC.
// Define MIXCOL_INV_EN to also exercise the Decrypt path.
module tb_mix_column_iter;

    logic         clk = 1'b0;
    logic         reset;
    logic [0:127] Data_In;
    logic         In_Valid;
    logic         In_Ready;
    logic         Last_Round;
    logic [0:127] Data_Out;
    logic         Out_Valid;
    logic         Out_Ready;
    logic         dec_drv;

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:127] exp_q[$];

    typedef struct {
        string        name;
        logic [0:127] din;
        logic         last;
        logic         dec;
        logic [0:127] exp;
    } vec_t;

    vec_t vecs[$];

    mix_column_iter dut (
        .clk       (clk),
        .reset     (reset),
        .Data_In   (Data_In),
        .In_Valid  (In_Valid),
        .In_Ready  (In_Ready),
        .Last_Round(Last_Round),
`ifdef MIXCOL_INV_EN
        .Decrypt   (dec_drv),
`endif
        .Data_Out  (Data_Out),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready)
    );

    initial forever #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    // Wait (bounded) for In_Ready, present one state for one cycle.
    // Returns at the falling edge just after the accepting edge.
    task automatic drive_accept(input logic [0:127] din, input logic last, input logic dec);
        int w;
        w = 0;
        while (!In_Ready && w < 20) begin
            @(negedge clk);
            w++;
        end
        check("in_ready_before_accept", {127'h0, In_Ready}, 128'h1);
        Data_In    = din;
        Last_Round = last;
        dec_drv    = dec;
        In_Valid   = 1'b1;
        @(negedge clk);
        In_Valid   = 1'b0;
    endtask

    // Count cycles to Out_Valid from the accept, then pop and compare.
    task automatic wait_result(input string name, input int start);
        int cycles;
        logic [0:127] e;
        cycles = start;
        while (!Out_Valid && cycles < 20) begin
            @(negedge clk);
            cycles++;
        end
        check({name, "_latency"}, 128'(cycles), 128'd4);
        e = exp_q.pop_front();
        if (Out_Valid) begin
            check({name, "_data"}, Data_Out, e);
        end
    endtask

    // One-cycle Out_Ready pulse; block must be back in IDLE afterwards.
    task automatic release_out(input string name);
        Out_Ready = 1'b1;
        @(negedge clk);
        Out_Ready = 1'b0;
        check({name, "_idle_flags"}, {126'h0, Out_Valid, In_Ready}, 128'h1);
    endtask

    logic [0:127] snap;
    logic         saw_valid;

    initial begin
        vecs.push_back('{"fips_round1", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0,
                         128'h046681e5e0cb199a48f8d37a2806264c});
        vecs.push_back('{"column_vec", 128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0,
                         128'h8e4da1bc9fdc589d01010101c6c6c6c6});
        vecs.push_back('{"bypass_col", 128'hdb135345f20a225c01010101c6c6c6c6, 1'b1, 1'b0,
                         128'hdb135345f20a225c01010101c6c6c6c6});
        vecs.push_back('{"column_vec2", 128'h2d26314cd4d4d4d5db135345f20a225c, 1'b0, 1'b0,
                         128'h4d7ebdf8d5d5d7d68e4da1bc9fdc589d});
        vecs.push_back('{"zeros", 128'h0, 1'b0, 1'b0, 128'h0});
        vecs.push_back('{"all_ff", {128{1'b1}}, 1'b0, 1'b0, {128{1'b1}}});
        vecs.push_back('{"bypass_fips", 128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b1, 1'b0,
                         128'hd4bf5d30e0b452aeb84111f11e2798e5});
`ifdef MIXCOL_INV_EN
        vecs.push_back('{"inverse", 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b0, 1'b1,
                         128'hdb135345f20a225c01010101c6c6c6c6});
        vecs.push_back('{"inverse_fips", 128'h046681e5e0cb199a48f8d37a2806264c, 1'b0, 1'b1,
                         128'hd4bf5d30e0b452aeb84111f11e2798e5});
        vecs.push_back('{"inverse_bypass", 128'h8e4da1bc9fdc589d01010101c6c6c6c6, 1'b1, 1'b1,
                         128'h8e4da1bc9fdc589d01010101c6c6c6c6});
`endif

        reset      = 1'b1;
        Data_In    = 128'h0;
        In_Valid   = 1'b0;
        Last_Round = 1'b0;
        Out_Ready  = 1'b0;
        dec_drv    = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_data_out", Data_Out, 128'h0);
        check("reset_flags", {126'h0, Out_Valid, In_Ready}, 128'h1);
        reset = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", {127'h0, In_Ready}, 128'h1);

        // Table-driven vectors through the scoreboard.
        foreach (vecs[i]) begin
            drive_accept(vecs[i].din, vecs[i].last, vecs[i].dec);
            exp_q.push_back(vecs[i].exp);
            wait_result(vecs[i].name, 0);
            release_out(vecs[i].name);
        end

        // Backpressure: result frozen, second In_Valid ignored.
        drive_accept(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0);
        exp_q.push_back(128'h046681e5e0cb199a48f8d37a2806264c);
        wait_result("bp", 0);
        snap = Data_Out;
        for (int i = 0; i < 10; i++) begin
            In_Valid = (i == 3);
            Data_In  = (i == 3) ? {128{1'b1}} : 128'h0;
            @(negedge clk);
            check("bp_hold_data", Data_Out, snap);
            check("bp_hold_flags", {126'h0, Out_Valid, In_Ready}, 128'h2);
        end
        In_Valid = 1'b0;
        release_out("bp");
        check("bp_data_kept_after_handshake", Data_Out, snap);

        // Column order: after one CALC edge only column 0 has been replaced.
        drive_accept(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0);
        exp_q.push_back(128'h8e4da1bc9fdc589d01010101c6c6c6c6);
        @(negedge clk);
        check("progress_col0", Data_Out, {32'h8e4da1bc, snap[32:127]});
        wait_result("progress", 1);
        release_out("progress");

        // Out_Ready high throughout: still must reach DONE for one cycle.
        Out_Ready = 1'b1;
        drive_accept(128'h2d26314cd4d4d4d5db135345f20a225c, 1'b0, 1'b0);
        exp_q.push_back(128'h4d7ebdf8d5d5d7d68e4da1bc9fdc589d);
        wait_result("ready_early", 0);
        @(negedge clk);
        Out_Ready = 1'b0;
        check("ready_early_idle", {126'h0, Out_Valid, In_Ready}, 128'h1);

        // Reset two cycles after accept discards the computation.
        drive_accept(128'hd4bf5d30e0b452aeb84111f11e2798e5, 1'b0, 1'b0);
        @(negedge clk);
        reset = 1'b1;
        Out_Ready = 1'b1;
        @(negedge clk);
        Out_Ready = 1'b0;
        check("rst_mid_data_out", Data_Out, 128'h0);
        check("rst_mid_flags", {126'h0, Out_Valid, In_Ready}, 128'h1);
        reset = 1'b0;
        @(negedge clk);
        check("rst_release_in_ready", {127'h0, In_Ready}, 128'h1);
        saw_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            saw_valid = saw_valid | Out_Valid;
        end
        check("rst_no_stale_result", {127'h0, saw_valid}, 128'h0);
        check("rst_data_still_zero", Data_Out, 128'h0);
        drive_accept(128'hdb135345f20a225c01010101c6c6c6c6, 1'b0, 1'b0);
        exp_q.push_back(128'h8e4da1bc9fdc589d01010101c6c6c6c6);
        wait_result("after_rst", 0);
        release_out("after_rst");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
